// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side signals of the dmem arbiter, plus its debug state.
// req/gnt: a requester holds req (with we/addr/wdata stable) until it sees the
// one-cycle gnt pulse, and must drop req in that same cycle; done marks rdata valid.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_data;
  logic              dmem_wren;
  logic [DATA_W-1:0] dmem_q;
  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dmem_q,
    output gnt0, gnt1, done0, done1, rdata, dmem_address, dmem_data,
           dmem_wren, busy, dbg_state
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dmem_q,
    input  gnt0, gnt1, done0, done1, rdata, dmem_address, dmem_data,
           dmem_wren, busy, dbg_state
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select. DMEM_ARB_ROUND_ROBIN_EN selects round-robin
// (rr_ptr names the favoured port); otherwise port 0 wins unless force_host.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  logic rr_ptr,
`else
  input  logic force_host,
`endif
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner = rr_ptr;
`else
      winner = force_host ? PORT_HOST : PORT_CPU;
`endif
    end else begin
      winner = req1 ? PORT_HOST : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port dmem: IDLE -> ISSUE -> DATA per access.
// Build option DMEM_ARB_ROUND_ROBIN_EN swaps fixed priority + MAX_WAIT guard for round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick_valid, pick_winner;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Holds the port favoured at the next contest: the one not granted last time.
  logic rr_q, rr_d;
`else
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WCW-1:0] wait_q, wait_d;
  logic           force_host;
  assign force_host = (MAX_WAIT > 0) && (wait_q == WCW'(MAX_WAIT));
`endif

  dmem_arb_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .rr_ptr     (rr_q),
`else
    .force_host (force_host),
`endif
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`else
    wait_d  = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          win_d   = pick_winner;
          if (pick_winner == PORT_HOST) begin
            gnt1_d = 1'b1;
            addr_d = bus.addr1;
            data_d = bus.wdata1;
            wren_d = bus.we1;
          end else begin
            gnt0_d = 1'b1;
            addr_d = bus.addr0;
            data_d = bus.wdata0;
            wren_d = bus.we0;
          end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          rr_d = ~pick_winner;
`else
          if (pick_winner == PORT_HOST) wait_d = '0;
          else if (bus.req1)            wait_d = wait_q + 1'b1;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      ISSUE: begin
        state_d = DATA;
        done0_d = (win_q == PORT_CPU);
        done1_d = (win_q == PORT_HOST);
      end
      DATA: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Async clear of wren guarantees no write escapes once reset is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= PORT_CPU;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_q    <= PORT_CPU;
`else
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`else
      wait_q  <= wait_d;
`endif
    end
  end

  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.done0        = done0_q;
  assign bus.done1        = done1_q;
  assign bus.dmem_wren    = wren_q;
  assign bus.dmem_address = addr_q;
  assign bus.dmem_data    = data_q;
  assign bus.busy         = busy_q;
  assign bus.rdata        = bus.dmem_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: syncram model, directed scenarios and randomized traffic
// checked against an access-level arbitration/memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int MAXC     = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Syncram model with a backdoor write port for preloading.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;
  always @(posedge clock) begin
    if (bus.dmem_wren) mem[bus.dmem_address] <= bus.dmem_data;
    if (bd_we)         mem[bd_addr] <= bd_data;
    bus.dmem_q <= mem[bus.dmem_address];
  end

  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q[$];
  int gnt_log[$];
  int gnt_cyc[$];
  int total = 0;
  int bad   = 0;
  int m_losses = 0;
  bit m_fav    = 1'b0;

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_losses = 0;
    m_fav = 1'b0;
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read0(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] rd,
                          output logic seen_done);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a;
    @(negedge clock);
    bus.req0 = 1'b0;
    @(negedge clock);
    rd = bus.rdata;
    seen_done = bus.done0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.dmem_wren, bus.busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.dmem_wren, bus.busy});
    end
    total++;
    if (bus.dmem_address !== '0 || bus.dmem_data !== '0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h want 0", bus.dmem_address, bus.dmem_data);
    end
    total++;
    if (bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want=0", bus.dbg_state);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_read();
    preload(12'h010, 32'h0000_00AB);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
    @(negedge clock);
    total++;
    if (bus.gnt0 !== 1'b1 || bus.done0 !== 1'b0 || bus.dmem_wren !== 1'b0 ||
        bus.dmem_address !== 12'h010) begin
      bad++;
      $display("FAIL single_gnt gnt0=%b done0=%b wren=%b addr=%h want 1 0 0 010",
               bus.gnt0, bus.done0, bus.dmem_wren, bus.dmem_address);
    end
    total++;
    if ({bus.gnt1, bus.done1} !== 2'b00) begin
      bad++;
      $display("FAIL single_p1_c1 got=%b want=00", {bus.gnt1, bus.done1});
    end
    bus.req0 = 1'b0;
    @(negedge clock);
    total++;
    if (bus.done0 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.rdata !== 32'h0000_00AB) begin
      bad++;
      $display("FAIL single_done done0=%b gnt0=%b rdata=%h want 1 0 000000ab",
               bus.done0, bus.gnt0, bus.rdata);
    end
    total++;
    if ({bus.gnt1, bus.done1} !== 2'b00) begin
      bad++;
      $display("FAIL single_p1_c2 got=%b want=00", {bus.gnt1, bus.done1});
    end
    @(negedge clock);
    total++;
    if (bus.done0 !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end done0=%b busy=%b want 0 0", bus.done0, bus.busy);
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] rd;
    logic              dn;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h7FF; bus.wdata1 = 32'hDEAD_BEEF;
    @(negedge clock);
    total++;
    if (bus.gnt1 !== 1'b1 || bus.dmem_wren !== 1'b1 || bus.dmem_address !== 12'h7FF ||
        bus.dmem_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL wr_issue gnt1=%b wren=%b addr=%h data=%h want 1 1 7ff deadbeef",
               bus.gnt1, bus.dmem_wren, bus.dmem_address, bus.dmem_data);
    end
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    @(negedge clock);
    total++;
    if (bus.dmem_wren !== 1'b0 || bus.done1 !== 1'b1) begin
      bad++;
      $display("FAIL wr_data wren=%b done1=%b want 0 1", bus.dmem_wren, bus.done1);
    end
    @(negedge clock);
    total++;
    if (bus.dmem_wren !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_idle wren=%b busy=%b want 0 0", bus.dmem_wren, bus.busy);
    end
    ref_mem[12'h7FF] = 32'hDEAD_BEEF;
    do_read0(12'h7FF, rd, dn);
    total++;
    if (dn !== 1'b1 || rd !== ref_mem[12'h7FF]) begin
      bad++;
      $display("FAIL wr_readback done0=%b rdata=%h want 1 %h", dn, rd, ref_mem[12'h7FF]);
    end
  endtask

  // Cycle engine: drives requests per mode and checks every output cycle against
  // an access-level model. Modes: 0 random, 1 both continuous, 2 port0 only,
  // 3 port1 continuous then port0 joins from cycle 3.
  task automatic run_traffic(input int cycles, input int mode);
    bit                e_g0 [0:MAXC-1];
    bit                e_g1 [0:MAXC-1];
    bit                e_d0 [0:MAXC-1];
    bit                e_d1 [0:MAXC-1];
    bit                e_we [0:MAXC-1];
    bit                e_rd [0:MAXC-1];
    logic [ADDR_W-1:0] e_ad [0:MAXC-1];
    logic [DATA_W-1:0] e_wd [0:MAXC-1];
    logic [DATA_W-1:0] exp_rd;
    int phase;
    int k;
    bit w, want0, want1, wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    for (int i = 0; i < MAXC; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_d0[i] = 0; e_d1[i] = 0; e_we[i] = 0; e_rd[i] = 0;
      e_ad[i] = '0; e_wd[i] = '0;
    end
    phase = 0;
    k = 0;
    while (1) begin
      total++;
      if (bus.gnt0 !== e_g0[k] || bus.gnt1 !== e_g1[k]) begin
        bad++;
        $display("FAIL traffic_gnt cyc=%0d got=%b%b want=%b%b", k, bus.gnt0, bus.gnt1, e_g0[k], e_g1[k]);
      end
      total++;
      if (bus.done0 !== e_d0[k] || bus.done1 !== e_d1[k]) begin
        bad++;
        $display("FAIL traffic_done cyc=%0d got=%b%b want=%b%b", k, bus.done0, bus.done1, e_d0[k], e_d1[k]);
      end
      total++;
      if (bus.dmem_wren !== e_we[k]) begin
        bad++;
        $display("FAIL traffic_wren cyc=%0d got=%b want=%b", k, bus.dmem_wren, e_we[k]);
      end
      if (e_g0[k] || e_g1[k]) begin
        total++;
        if (bus.dmem_address !== e_ad[k] || (e_we[k] && bus.dmem_data !== e_wd[k])) begin
          bad++;
          $display("FAIL traffic_bus cyc=%0d addr=%h data=%h want %h %h", k,
                   bus.dmem_address, bus.dmem_data, e_ad[k], e_wd[k]);
        end
      end
      if (e_rd[k] && exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        total++;
        if (bus.rdata !== exp_rd) begin
          bad++;
          $display("FAIL traffic_rdata cyc=%0d got=%h want=%h", k, bus.rdata, exp_rd);
        end
      end
      if (bus.gnt0) begin gnt_log.push_back(0); gnt_cyc.push_back(k); end
      if (bus.gnt1) begin gnt_log.push_back(1); gnt_cyc.push_back(k); end

      if (k >= cycles && phase == 0 && !bus.req0 && !bus.req1) break;
      if (k >= MAXC - 8) begin
        bad++; total++;
        $display("FAIL traffic_timeout cyc=%0d got=running want=drained", k);
        break;
      end

      if (bus.gnt0) bus.req0 = 1'b0;
      if (bus.gnt1) bus.req1 = 1'b0;
      case (mode)
        0:       begin want0 = ($urandom_range(0, 3) == 0); want1 = ($urandom_range(0, 3) == 0); end
        1:       begin want0 = 1'b1; want1 = 1'b1; end
        2:       begin want0 = 1'b1; want1 = 1'b0; end
        default: begin want0 = (k >= 3); want1 = 1'b1; end
      endcase
      if (k < cycles) begin
        if (!bus.req0 && !bus.gnt0 && want0) begin
          bus.req0 = 1'b1; bus.we0 = 1'($urandom_range(0, 1));
          bus.addr0 = 12'h100 + 12'($urandom_range(0, 15)); bus.wdata0 = $urandom;
        end
        if (!bus.req1 && !bus.gnt1 && want1) begin
          bus.req1 = 1'b1; bus.we1 = 1'($urandom_range(0, 1));
          bus.addr1 = 12'h100 + 12'($urandom_range(0, 15)); bus.wdata1 = $urandom;
        end
      end

      if (phase == 0 && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          w = m_fav;
`else
          w = (MAX_WAIT > 0) && (m_losses == MAX_WAIT);
`endif
        end else begin
          w = bus.req1;
        end
        m_fav = ~w;
        if (w) m_losses = 0;
        else if (bus.req1) m_losses++;
        wv = w ? bus.we1 : bus.we0;
        wa = w ? bus.addr1 : bus.addr0;
        wd = w ? bus.wdata1 : bus.wdata0;
        if (w) begin e_g1[k+1] = 1; e_d1[k+2] = 1; end
        else   begin e_g0[k+1] = 1; e_d0[k+2] = 1; end
        e_we[k+1] = wv; e_ad[k+1] = wa; e_wd[k+1] = wd;
        if (wv) ref_mem[wa] = wd;
        else begin e_rd[k+2] = 1; exp_q.push_back(ref_mem[wa]); end
        phase = 1;
      end else if (phase == 1) phase = 2;
      else if (phase == 2) phase = 0;

      @(negedge clock);
      k++;
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    int want [10];
    do_reset();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    want = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    want = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    gnt_log.delete(); gnt_cyc.delete();
    run_traffic(40, 1);
    total++;
    if (gnt_log.size() < 10) begin
      bad++;
      $display("FAIL contention_count got=%0d want>=10", gnt_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (gnt_log[i] != want[i]) begin
          bad++;
          $display("FAIL contention_order idx=%0d got=%0d want=%0d", i, gnt_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_lone_then_contend();
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    run_traffic(6, 3);
    total++;
    if (gnt_log.size() < 2 || gnt_log[0] != 1 || gnt_log[1] != 0) begin
      bad++;
      $display("FAIL lone_then_contend n=%0d first=%0d second=%0d want 1 0", gnt_log.size(),
               gnt_log.size() > 0 ? gnt_log[0] : -1, gnt_log.size() > 1 ? gnt_log[1] : -1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    run_traffic(30, 2);
    total++;
    if (gnt_cyc.size() < 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d want>=8", gnt_cyc.size());
    end
    for (int i = 1; i < gnt_cyc.size(); i++) begin
      total++;
      if (gnt_cyc[i] - gnt_cyc[i-1] != 3 || gnt_log[i] != 0) begin
        bad++;
        $display("FAIL b2b_spacing idx=%0d got=%0d port=%0d want=3 port=0", i,
                 gnt_cyc[i] - gnt_cyc[i-1], gnt_log[i]);
      end
    end
  endtask

  task automatic test_random();
    gnt_log.delete(); gnt_cyc.delete();
    run_traffic(300, 0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [DATA_W-1:0] rd;
    logic              dn;
    preload(12'h020, 32'h1111_1111);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h020; bus.wdata1 = 32'h5555_AAAA;
    @(negedge clock);
    total++;
    if (bus.gnt1 !== 1'b1 || bus.dmem_wren !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre gnt1=%b wren=%b want 1 1", bus.gnt1, bus.dmem_wren);
    end
    #1;
    reset = 1'b1;
    idle_inputs();
    #1;
    total++;
    if (bus.dmem_wren !== 1'b0 || bus.busy !== 1'b0 || bus.gnt1 !== 1'b0 || bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL rst_async wren=%b busy=%b gnt1=%b state=%0d want 0 0 0 0",
               bus.dmem_wren, bus.busy, bus.gnt1, bus.dbg_state);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_losses = 0;
    m_fav = 1'b0;
    @(negedge clock);
    do_read0(12'h020, rd, dn);
    total++;
    if (dn !== 1'b1 || rd !== 32'h1111_1111) begin
      bad++;
      $display("FAIL rst_readback done0=%b rdata=%h want 1 11111111", dn, rd);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    for (int i = 0; i < 16; i++) preload(12'h100 + 12'(i), $urandom);
    test_contention();
    test_lone_then_contend();
    test_back_to_back();
    test_random();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
